// File: rtl/fetch.sv
// Instruction-fetch stage: owns PC_F, issues one-outstanding imem reads and drives IF/ID.
// Optional bubble counter on port fetchBubbles_F when FETCH_PERF_EN is defined.
module fetch #(
    parameter int          N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_F,
    output logic [N-1:0] imem_addr_F,
    input  logic         imem_ready_F,
    input  logic         imem_valid_F,
    input  logic [31:0]  imem_rdata_F,
    input  logic         stall_D,
    input  logic         pcSrc_E,
    input  logic [N-1:0] branchTarget_E,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D
`ifdef FETCH_PERF_EN
    ,
    output logic [N-1:0] fetchBubbles_F
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [N-1:0] pc_f, pc_n;
    logic         kill, kill_n;
    logic [31:0]  skid_instr, skid_instr_n;
    logic [N-1:0] skid_pc, skid_pc_n;

    logic         load_ok;
    logic         new_valid;
    logic [31:0]  new_instr;
    logic [N-1:0] new_pc;
    logic [N-1:0] redirect_pc;

    assign load_ok     = !valid_D || !stall_D;
    assign redirect_pc = branchTarget_E & ~N'(3);

    // Memory-facing outputs come straight from registers.
    assign imem_req_F  = (state == REQ);
    assign imem_addr_F = pc_f;

    always_comb begin
        state_n      = state;
        pc_n         = pc_f;
        kill_n       = kill;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        new_valid    = 1'b0;
        new_instr    = NOP;
        new_pc       = pc_f;

        case (state)
            REQ: begin
                if (imem_ready_F) state_n = WAIT;
            end
            WAIT: begin
                if (imem_valid_F) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else if (load_ok) begin
                        new_valid = 1'b1;
                        new_instr = imem_rdata_F;
                        new_pc    = pc_f;
                        pc_n      = pc_f + N'(4);
                        state_n   = REQ;
                    end else begin
                        skid_instr_n = imem_rdata_F;
                        skid_pc_n    = pc_f;
                        pc_n         = pc_f + N'(4);
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (load_ok) begin
                    new_valid = 1'b1;
                    new_instr = skid_instr;
                    new_pc    = skid_pc;
                    state_n   = REQ;
                end
            end
            default: state_n = REQ;
        endcase

        // A redirect overrides everything; an in-flight read is marked for discard.
        if (pcSrc_E) begin
            pc_n = redirect_pc;
            case (state)
                REQ: begin
                    state_n = imem_ready_F ? WAIT : REQ;
                    kill_n  = imem_ready_F;
                end
                WAIT: begin
                    state_n = imem_valid_F ? REQ : WAIT;
                    kill_n  = !imem_valid_F;
                end
                default: begin
                    state_n = REQ;
                    kill_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            pc_f       <= RESET_PC;
            kill       <= 1'b0;
            skid_instr <= NOP;
            skid_pc    <= '0;
        end else begin
            state      <= state_n;
            pc_f       <= pc_n;
            kill       <= kill_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
        end
    end

    // IF/ID register: flush on redirect, otherwise advance only when decode can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_D <= NOP;
            pc_D    <= '0;
            valid_D <= 1'b0;
        end else if (pcSrc_E) begin
            instr_D <= NOP;
            valid_D <= 1'b0;
        end else if (load_ok) begin
            if (new_valid) begin
                instr_D <= new_instr;
                pc_D    <= new_pc;
                valid_D <= 1'b1;
            end else begin
                instr_D <= NOP;
                valid_D <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetchBubbles_F <= '0;
        else if (!valid_D)
            fetchBubbles_F <= fetchBubbles_F + N'(1);
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Table-driven bench for fetch, plus hand sequences for async reset and the bubble counter.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_F;
    logic [63:0] imem_addr_F;
    logic        imem_ready_F;
    logic        imem_valid_F;
    logic [31:0] imem_rdata_F;
    logic        stall_D;
    logic        pcSrc_E;
    logic [63:0] branchTarget_E;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
`ifdef FETCH_PERF_EN
    logic [63:0] fetchBubbles_F;
`endif

    int total = 0;
    int bad   = 0;

    fetch #(.N(64), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_F     (imem_req_F),
        .imem_addr_F    (imem_addr_F),
        .imem_ready_F   (imem_ready_F),
        .imem_valid_F   (imem_valid_F),
        .imem_rdata_F   (imem_rdata_F),
        .stall_D        (stall_D),
        .pcSrc_E        (pcSrc_E),
        .branchTarget_E (branchTarget_E),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .valid_D        (valid_D)
`ifdef FETCH_PERF_EN
        ,
        .fetchBubbles_F (fetchBubbles_F)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] rdata;
        logic        stall;
        logic        pcsrc;
        logic [63:0] target;
        logic        e_req;
        logic [63:0] e_addr;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ready, logic valid, logic [31:0] rdata, logic stall,
                                logic pcsrc, logic [63:0] target, logic e_req,
                                logic [63:0] e_addr, logic [31:0] e_instr,
                                logic [63:0] e_pc, logic e_valid);
        vec_t v;
        v.ready = ready; v.valid = valid; v.rdata = rdata; v.stall = stall;
        v.pcsrc = pcsrc; v.target = target; v.e_req = e_req; v.e_addr = e_addr;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic applyStimulus(input logic ready, input logic valid, input logic [31:0] rdata,
                                 input logic stall, input logic pcsrc, input logic [63:0] target);
        imem_ready_F   = ready;
        imem_valid_F   = valid;
        imem_rdata_F   = rdata;
        stall_D        = stall;
        pcSrc_E        = pcsrc;
        branchTarget_E = target;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_req, input logic [63:0] e_addr,
                               input logic [31:0] e_instr, input logic [63:0] e_pc,
                               input logic e_valid);
        checkVal({name, ".req"},   64'(imem_req_F), 64'(e_req));
        checkVal({name, ".addr"},  imem_addr_F,     e_addr);
        checkVal({name, ".instr"}, 64'(instr_D),    64'(e_instr));
        checkVal({name, ".pc"},    pc_D,            e_pc);
        checkVal({name, ".valid"}, 64'(valid_D),    64'(e_valid));
    endtask

    initial begin
        //             rdy vld rdata         stl src target                 req addr                   instr          pc_D                   v
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'h0,                NOP,           64'h0,                0));
        vecs.push_back(mk(0, 1, 32'h00500093, 0, 0, 64'h0,                1, 64'h4,                32'h00500093,  64'h0,                1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'h4,                NOP,           64'h0,                0));
        vecs.push_back(mk(0, 1, 32'h00A00113, 0, 0, 64'h0,                1, 64'h8,                32'h00A00113,  64'h4,                1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 64'h0,                0, 64'h8,                32'h00A00113,  64'h4,                1));
        vecs.push_back(mk(0, 1, 32'h00308193, 1, 0, 64'h0,                0, 64'hC,                32'h00A00113,  64'h4,                1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 64'h0,                0, 64'hC,                32'h00A00113,  64'h4,                1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 64'h0,                1, 64'hC,                32'h00308193,  64'h8,                1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'hC,                NOP,           64'h8,                0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 64'h100,              0, 64'h100,              NOP,           64'h8,                0));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 64'h0,                1, 64'h100,              NOP,           64'h8,                0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'h100,              NOP,           64'h8,                0));
        vecs.push_back(mk(0, 1, 32'h00000493, 0, 0, 64'h0,                1, 64'h104,              32'h00000493,  64'h100,              1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 64'h203,              1, 64'h200,              NOP,           64'h100,              0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'h200,              NOP,           64'h100,              0));
        vecs.push_back(mk(0, 1, 32'h00100513, 0, 0, 64'h0,                1, 64'h204,              32'h00100513,  64'h200,              1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 64'hFFFFFFFFFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC, NOP,           64'h200,              0));
        vecs.push_back(mk(0, 1, 32'h11111111, 0, 0, 64'h0,                1, 64'hFFFFFFFFFFFFFFFC, NOP,           64'h200,              0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'hFFFFFFFFFFFFFFFC, NOP,           64'h200,              0));
        vecs.push_back(mk(0, 1, 32'h00200593, 0, 0, 64'h0,                1, 64'h0,                32'h00200593,  64'hFFFFFFFFFFFFFFFC, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 64'h0,                0, 64'h0,                32'h00200593,  64'hFFFFFFFFFFFFFFFC, 1));
        vecs.push_back(mk(0, 1, 32'h22222222, 1, 0, 64'h0,                0, 64'h4,                32'h00200593,  64'hFFFFFFFFFFFFFFFC, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 64'h40,               1, 64'h40,               NOP,           64'hFFFFFFFFFFFFFFFC, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 64'h0,                0, 64'h40,               NOP,           64'hFFFFFFFFFFFFFFFC, 0));
        vecs.push_back(mk(0, 1, 32'h33333333, 0, 0, 64'h0,                1, 64'h44,               32'h33333333,  64'h40,               1));
        vecs.push_back(mk(0, 1, 32'h44444444, 0, 0, 64'h0,                1, 64'h44,               NOP,           64'h40,               0));

        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", 1, 64'h0, NOP, 64'h0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ready, vecs[i].valid, vecs[i].rdata,
                          vecs[i].stall, vecs[i].pcsrc, vecs[i].target);
            @(negedge clk);
            checkOutput($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                        vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid);
        end

        // Reset asserted while a read is outstanding takes effect without a clock edge.
        applyStimulus(1, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        checkOutput("pre_midrst", 0, 64'h44, NOP, 64'h40, 0);
        #2;
        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 0, 64'h0);
        #1;
        checkOutput("midrst", 1, 64'h0, NOP, 64'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 32'h0BAD0BAD, 0, 0, 64'h0);
        @(negedge clk);
        checkOutput("late_valid", 1, 64'h0, NOP, 64'h0, 0);

        // Five bubble cycles from reset release to the first valid instruction.
        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1, 0, 32'h0, 0, 0, 64'h0);
        @(negedge clk);
        applyStimulus(0, 1, 32'h00500093, 1, 0, 64'h0);
        @(negedge clk);
        applyStimulus(0, 0, 32'h0, 1, 0, 64'h0);
        @(negedge clk);
        checkOutput("bubbles", 1, 64'h4, 32'h00500093, 64'h0, 1);
`ifdef FETCH_PERF_EN
        checkVal("bubble_count", fetchBubbles_F, 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
